// File: rtl/smac_load_pkg.sv
// Shared definitions for the SMAC operand load path: FSM states, lane
// geometry and the lane-limit clamp helper.
package smac_load_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } load_state_t;

    localparam int LANE_IDX_W  = 2;
    localparam int MAX_LANES_C = 4;

    // A lane limit is 0..4; anything above the lane count saturates to 4.
    function automatic logic [2:0] clamp_lim(input logic [2:0] v);
        logic [2:0] r;
        if (v > 3'd4) begin
            r = 3'd4;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/load_lane_bank.sv
// Lane register file for the operand load demux: MAX_LANES_C words of DATA_W
// bits with per-lane "written this sequence" flags, a valid-clear, and a
// zero-fill strobe that blanks every lane at or above fill_lim.
module load_lane_bank
    import smac_load_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [LANE_IDX_W-1:0]         wr_idx,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          clr_valid,
    input  logic                          zero_fill,
    input  logic [2:0]                    fill_lim,
    output logic [MAX_LANES_C*DATA_W-1:0] lane_data,
    output logic [MAX_LANES_C-1:0]        lane_valid
);

    logic [DATA_W-1:0]      lane_q [MAX_LANES_C];
    logic [DATA_W-1:0]      lane_d [MAX_LANES_C];
    logic [MAX_LANES_C-1:0] valid_q;
    logic [MAX_LANES_C-1:0] valid_d;

    // Next lane contents: zero-fill first, then the (mutually exclusive) write.
    always_comb begin
        for (int i = 0; i < MAX_LANES_C; i++) begin
            if (zero_fill && (3'(i) >= fill_lim)) begin
                lane_d[i] = '0;
            end else begin
                lane_d[i] = lane_q[i];
            end
        end
        if (clr_valid) begin
            valid_d = '0;
        end else begin
            valid_d = valid_q;
        end
        if (wr_en) begin
            lane_d[wr_idx]  = wr_data;
            valid_d[wr_idx] = 1'b1;
        end else begin
            valid_d = valid_d;
        end
    end

    // Lane and valid registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_LANES_C; i++) begin
                lane_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int i = 0; i < MAX_LANES_C; i++) begin
                lane_q[i] <= lane_d[i];
            end
            valid_q <= valid_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < MAX_LANES_C; g++) begin : g_pack
            assign lane_data[g*DATA_W +: DATA_W] = lane_q[g];
        end
    endgenerate

    assign lane_valid = valid_q;

endmodule

// File: rtl/ctrl_cnt_load_demux.sv
// Operand load demux: accepts a serial valid/ready word stream and scatters
// it into up to four lane registers using an internal lane counter, then
// pulses load_done for one cycle.
// Optional feature macro: LOAD_ZERO_FILL_EN -- when defined, lanes at or
// above the programmed limit are zeroed on entry to FILL.
module ctrl_cnt_load_demux
    import smac_load_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int MAX_LANES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cnt_clear,
    input  logic                        cnt_load,
    input  logic [2:0]                  max_val,
    input  logic                        start,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        in_ready,
    output logic [LANE_IDX_W-1:0]       sel_demux,
    output logic [MAX_LANES*DATA_W-1:0] lane_data,
    output logic [MAX_LANES-1:0]        lane_valid,
    output logic                        busy,
    output logic                        load_done
);

    load_state_t           state_q, state_d;
    logic [LANE_IDX_W-1:0] idx_q, idx_d;
    logic [2:0]            lim_q, lim_d;
    logic                  wr_en_s;
    logic                  clr_valid_s;
    logic                  zero_fill_s;
    logic                  last_beat_s;

    // The limit is never 0 while in FILL, so lim-1 does not wrap there.
    assign last_beat_s = ({1'b0, idx_q} == (lim_q - 3'd1));

    // Next-state, counter and lane-bank control with clear > load > start > beat.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lim_d       = lim_q;
        wr_en_s     = 1'b0;
        clr_valid_s = 1'b0;
        zero_fill_s = 1'b0;
        if (cnt_clear) begin
            state_d     = IDLE;
            idx_d       = '0;
            clr_valid_s = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cnt_load) begin
                        lim_d = clamp_lim(max_val);
                    end else if (start && (lim_q != 3'd0)) begin
                        state_d     = FILL;
                        idx_d       = '0;
                        clr_valid_s = 1'b1;
`ifdef LOAD_ZERO_FILL_EN
                        zero_fill_s = 1'b1;
`else
                        zero_fill_s = 1'b0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        wr_en_s = 1'b1;
                        if (last_beat_s) begin
                            state_d = DONE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else begin
                        idx_d = idx_q;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // FSM state, lane index and lane limit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lim_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lim_q   <= lim_d;
        end
    end

    load_lane_bank #(
        .DATA_W (DATA_W)
    ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en_s),
        .wr_idx     (idx_q),
        .wr_data    (in_data),
        .clr_valid  (clr_valid_s),
        .zero_fill  (zero_fill_s),
        .fill_lim   (lim_q),
        .lane_data  (lane_data),
        .lane_valid (lane_valid)
    );

    // Status outputs decoded from registered state only.
    always_comb begin
        in_ready  = (state_q == FILL);
        busy      = (state_q != IDLE);
        load_done = (state_q == DONE);
        if (state_q == FILL) begin
            sel_demux = idx_q;
        end else begin
            sel_demux = '0;
        end
    end

endmodule

// File: tb/tb_ctrl_cnt_load_demux.sv
// Directed self-checking bench for ctrl_cnt_load_demux.
module tb_ctrl_cnt_load_demux;

    logic        clk = 1'b0;
    logic        rst;
    logic        cnt_clear;
    logic        cnt_load;
    logic [2:0]  max_val;
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [1:0]  sel_demux;
    logic [63:0] lane_data;
    logic [3:0]  lane_valid;
    logic        busy;
    logic        load_done;

    int checks   = 0;
    int failures = 0;

    ctrl_cnt_load_demux #(.DATA_W(16), .MAX_LANES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_clear  (cnt_clear),
        .cnt_load   (cnt_load),
        .max_val    (max_val),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .sel_demux  (sel_demux),
        .lane_data  (lane_data),
        .lane_valid (lane_valid),
        .busy       (busy),
        .load_done  (load_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_lim(input logic [2:0] v);
        cnt_load = 1'b1;
        max_val  = v;
        step();
        cnt_load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic beat(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    logic [63:0] exp_lanes;

    initial begin
        rst = 1'b1; cnt_clear = 1'b0; cnt_load = 1'b0; max_val = 3'd0;
        start = 1'b0; in_valid = 1'b0; in_data = 16'h0000;
        step(); step();
        rst = 1'b0;

        // Reset state
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_sel", 64'(sel_demux), 64'd0);
        check("rst_lanes", lane_data, 64'd0);
        check("rst_valid", 64'(lane_valid), 64'd0);
        check("rst_done", 64'(load_done), 64'd0);

        // 4 back-to-back beats
        load_lim(3'd4);
        do_start();
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 16'((k + 1) * 16'h0011);
            check($sformatf("t1_sel%0d", k), 64'(sel_demux), 64'(k));
            check($sformatf("t1_nodone%0d", k), 64'(load_done), 64'd0);
            step();
        end
        in_valid = 1'b0;
        check("t1_done", 64'(load_done), 64'd1);
        check("t1_ready_done", 64'(in_ready), 64'd0);
        check("t1_lanes", lane_data, 64'h0044_0033_0022_0011);
        check("t1_valid", 64'(lane_valid), 64'hF);
        step();
        check("t1_done_once", 64'(load_done), 64'd0);
        check("t1_idle", 64'(busy), 64'd0);

        // max_val=2 with 3-cycle gaps
        load_lim(3'd2);
        do_start();
        step(); step(); step();
        check("t2_sel_gap0", 64'(sel_demux), 64'd0);
        beat(16'hAAAA);
        step(); step(); step();
        check("t2_sel_gap1", 64'(sel_demux), 64'd1);
        check("t2_valid_mid", 64'(lane_valid), 64'h1);
        check("t2_nodone", 64'(load_done), 64'd0);
        beat(16'hBBBB);
        check("t2_done", 64'(load_done), 64'd1);
        check("t2_valid", 64'(lane_valid), 64'h3);
`ifdef LOAD_ZERO_FILL_EN
        exp_lanes = 64'h0000_0000_BBBB_AAAA;
`else
        exp_lanes = 64'h0044_0033_BBBB_AAAA;
`endif
        check("t2_lanes", lane_data, exp_lanes);
        step();

        // cnt_clear during FILL with a simultaneous beat
        do_start();
        beat(16'h1111);
        cnt_clear = 1'b1; in_valid = 1'b1; in_data = 16'h9999;
        step();
        cnt_clear = 1'b0; in_valid = 1'b0;
        check("t3_busy", 64'(busy), 64'd0);
        check("t3_ready", 64'(in_ready), 64'd0);
        check("t3_valid", 64'(lane_valid), 64'h0);
        check("t3_done", 64'(load_done), 64'd0);
        exp_lanes[31:0] = 32'hBBBB_1111;
        check("t3_lanes", lane_data, exp_lanes);
        step();
        check("t3_done_later", 64'(load_done), 64'd0);

        // max_val=0 then start: stays idle
        load_lim(3'd0);
        do_start();
        check("t4_busy0", 64'(busy), 64'd0);
        check("t4_ready0", 64'(in_ready), 64'd0);
        step();
        check("t4_busy0b", 64'(busy), 64'd0);

        // max_val=7 clamps to 4
        load_lim(3'd7);
        do_start();
        beat(16'h0001); beat(16'h0002); beat(16'h0003);
        check("t4_busy7", 64'(busy), 64'd1);
        check("t4_nodone7", 64'(load_done), 64'd0);
        check("t4_sel7", 64'(sel_demux), 64'd3);
        beat(16'h0004);
        check("t4_done7", 64'(load_done), 64'd1);
        check("t4_lanes7", lane_data, 64'h0004_0003_0002_0001);
        step();

        // rst mid-FILL
        load_lim(3'd4);
        do_start();
        beat(16'h5555);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_ready", 64'(in_ready), 64'd0);
        check("t5_sel", 64'(sel_demux), 64'd0);
        check("t5_lanes", lane_data, 64'd0);
        check("t5_valid", 64'(lane_valid), 64'd0);
        check("t5_done", 64'(load_done), 64'd0);
        do_start();
        check("t5_lim_cleared", 64'(busy), 64'd0);

        // 4-lane fill then 1-lane fill: zero-fill behaviour
        load_lim(3'd4);
        do_start();
        beat(16'h00A1); beat(16'h00A2); beat(16'h00A3); beat(16'h00A4);
        step();
        load_lim(3'd1);
        do_start();
`ifdef LOAD_ZERO_FILL_EN
        exp_lanes = 64'h0000_0000_0000_00A1;
`else
        exp_lanes = 64'h00A4_00A3_00A2_00A1;
`endif
        check("t5_zf_lanes", lane_data, exp_lanes);
        check("t5_zf_valid", 64'(lane_valid), 64'h0);
        beat(16'h00B1);
        check("t5_done1", 64'(load_done), 64'd1);
        check("t5_valid1", 64'(lane_valid), 64'h1);
        exp_lanes[15:0] = 16'h00B1;
        check("t5_lanes1", lane_data, exp_lanes);
        step();

        // cnt_load during FILL is ignored
        load_lim(3'd3);
        do_start();
        beat(16'h0C01);
        cnt_load = 1'b1; max_val = 3'd1;
        step();
        cnt_load = 1'b0;
        beat(16'h0C02);
        check("t6_nodone", 64'(load_done), 64'd0);
        check("t6_busy", 64'(busy), 64'd1);
        beat(16'h0C03);
        check("t6_done", 64'(load_done), 64'd1);
        check("t6_valid", 64'(lane_valid), 64'h7);
`ifdef LOAD_ZERO_FILL_EN
        exp_lanes = 64'h0000_0C03_0C02_0C01;
`else
        exp_lanes = 64'h00A4_0C03_0C02_0C01;
`endif
        check("t6_lanes", lane_data, exp_lanes);
        step();
        check("t6_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_cnt_load_demux.md
Name: ctrl_cnt_load_demux

Overview:
- Input-side counterpart of the write-back ReLU mux counter.
- Accepts a serial stream of operand words over a valid/ready handshake.
- Uses an internal lane counter to scatter the words into up to 4 parallel lane registers that feed the SMAC lanes.
- Signals load_done to the main FSM once the programmed number of lanes is filled.

Parameters:
- DATA_W, 16, width of each operand word and lane register.
- MAX_LANES, 4, number of lane registers; fixed at 4 by construction, so the lane index is 2 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cnt_clear  in  1  abort or clear; returns to IDLE and clears the lane index and lane_valid.
- cnt_load  in  1  latch max_val into the internal lane limit; honoured only in IDLE.
- max_val  in  3  number of lanes to fill, 1..4.
- start  in  1  begin a fill sequence; honoured only in IDLE.
- in_valid  in  1  upstream word valid.
- in_data  in  DATA_W  upstream word.
- in_ready  out  1  block accepts a word this cycle.
- sel_demux  out  2  lane index of the next word to be written.
- lane_data  out  MAX_LANES*DATA_W  lane registers; lane 0 occupies the LSBs.
- lane_valid  out  MAX_LANES  per-lane "written this sequence" flags.
- busy  out  1  high in FILL and DONE.
- load_done  out  1  one-cycle pulse when the fill completes.

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE, idx=0, lim=0.
  - lane_data=0, lane_valid=0, load_done=0.
  - in_ready=0, busy=0, sel_demux=0.
- Priority per cycle: rst > cnt_clear > cnt_load > start > handshake.
- cnt_load in IDLE: lim <= max_val.
  - max_val=0 stores 0.
  - max_val>4 stores 4 (clamp).
  - Ignored outside IDLE.
- FSM state IDLE: in_ready=0.
  - If start and lim!=0: go to FILL; idx <= 0; lane_valid <= 0.
  - If start and lim==0: stay in IDLE with no side effects.
- FSM state FILL: in_ready=1.
  - Beat = in_valid && in_ready.
  - On each beat: lane[idx] <= in_data; lane_valid[idx] <= 1.
  - If idx==lim-1: go to DONE and set idx <= 0. Otherwise idx <= idx+1.
  - No beat means no change; stalls of any length are allowed.
- FSM state DONE: in_ready=0; load_done=1 for exactly this one cycle; next state is IDLE.
- Latency: load_done is high in the cycle after the clock edge that accepted the last beat.
- sel_demux = idx in FILL, 0 otherwise. It is purely combinational from registered idx/state.
- busy = (state != IDLE).
- cnt_clear in any state:
  - Next state IDLE; idx=0; lane_valid=0; load_done=0.
  - lane_data and lim are retained.
  - A beat in the same cycle as cnt_clear is dropped.
- start in FILL or DONE is ignored; it is not queued.
- lane_data holds its value after DONE until the next accepted beat to the same lane, or until the zero-fill described below.

Optional Feature:
- Macro: LOAD_ZERO_FILL_EN.
- Defined: on the IDLE->FILL transition, lanes with index >= lim are cleared to 0 in the same edge, so unused lanes present zero operands.
- Undefined: unused lanes keep their previous contents. Only lane_valid identifies which lanes were written.

Decomposition:
- Shared package smac_load_pkg contains:
  - state enum load_state_t {IDLE, FILL, DONE}.
  - localparam LANE_IDX_W=2.
  - localparam MAX_LANES_C=4.
- Sub-module load_lane_bank: the MAX_LANES x DATA_W register file with write enable, write index, per-lane valid, clear, and the optional zero-fill input.
- The FSM, counter, and handshake logic stay in the top module.

Test Plan:
- cnt_load max_val=4, start, then 4 back-to-back beats 0x0011,0x0022,0x0033,0x0044:
  - sel_demux 0,1,2,3.
  - lane_data=0x0044_0033_0022_0011; lane_valid=4'b1111.
  - load_done pulses exactly once, one cycle after beat 4; in_ready=0 in DONE.
- max_val=2, beats spaced with 3-cycle in_valid gaps:
  - Only lanes 0 and 1 are written; lane_valid=4'b0011.
  - idx holds during the gaps; load_done follows beat 2.
- cnt_clear asserted during FILL after 1 beat, with in_valid=1 in the same cycle:
  - IDLE next cycle; lane_valid=0; no load_done.
  - The dropped word does not appear in lane 1.
- max_val=0 then start: stays in IDLE, busy=0, in_ready=0. max_val=7 then start: behaves exactly as lim=4.
- rst pulsed mid-FILL: all outputs at reset values on the next cycle. Repeat with LOAD_ZERO_FILL_EN defined and undefined, using max_val=1 after a prior 4-lane fill:
  - Defined: lanes 1..3 read 0.
  - Undefined: lanes 1..3 keep their old data.
- cnt_load issued during FILL with max_val=1 while lim=3: ignored; the fill completes after 3 beats.
